// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared state encoding and rate defaults for the SD-card SPI master.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam int   DIV_FAST_DEF  = 1;
    localparam int   DIV_SLOW_DEF  = 64;
    localparam logic SPI_IDLE_MOSI = 1'b1;

endpackage

// File: rtl/sd_spi_divider.sv
// sd_spi_divider: loadable down-counter; tick flags a zero count.
module sd_spi_divider #(
    parameter int CNTW = 7
) (
    input  logic            fclk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [CNTW-1:0] load_value,
    output logic            tick
);

    logic [CNTW-1:0] cnt;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/sd_spi_master.sv
// sd_spi_master: SPI mode-0 byte shifter for the SD card, slow init / fast data rates.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int DIV_FAST = DIV_FAST_DEF,
    parameter int DIV_SLOW = DIV_SLOW_DEF,
    parameter int CNTW     = 7
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       sd_start,
    input  logic [7:0] sd_datain,
    input  logic       speed,
    output logic [7:0] sd_dataout,
    output logic       busy,
    output logic       done,
    output logic       sdclk,
    output logic       sddo,
    input  logic       sddi
);

    localparam logic [CNTW-1:0] FAST_M1 = CNTW'(DIV_FAST - 1);
    localparam logic [CNTW-1:0] SLOW_M1 = CNTW'(DIV_SLOW - 1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] half_q, load_value;
    logic [6:0]      txsr;
    logic [7:0]      rxsr;
    logic [2:0]      bitcnt;
    logic            load, tick, last_bit;

    sd_spi_divider #(.CNTW(CNTW)) u_div (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (load_value),
        .tick       (tick)
    );

    assign last_bit = (bitcnt == 3'd7);

    always_comb begin
        state_d    = state_q;
        load       = (state_q == IDLE) ? sd_start : tick;
        load_value = (state_q == IDLE) ? (speed ? FAST_M1 : SLOW_M1) : half_q;
        case (state_q)
            IDLE:    state_d = sd_start ? LOW : IDLE;
            LOW:     state_d = tick ? HIGH : LOW;
            HIGH:    state_d = tick ? (last_bit ? IDLE : LOW) : HIGH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // txsr holds only the bits not yet placed on sddo; sddo itself carries the current bit
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            txsr       <= 7'h7F;
            rxsr       <= 8'hFF;
            bitcnt     <= '0;
            half_q     <= '0;
            sd_dataout <= 8'hFF;
            busy       <= 1'b0;
            done       <= 1'b0;
            sdclk      <= 1'b0;
            sddo       <= SPI_IDLE_MOSI;
        end else begin
            done <= 1'b0;
            if (state_q == IDLE && sd_start) begin
                txsr   <= sd_datain[6:0];
                sddo   <= sd_datain[7];
                half_q <= load_value;
                busy   <= 1'b1;
                bitcnt <= '0;
            end else if (state_q == LOW && tick) begin
                sdclk <= 1'b1;
                rxsr  <= {rxsr[6:0], sddi};
            end else if (state_q == HIGH && tick) begin
                sdclk <= 1'b0;
                if (last_bit) begin
                    sd_dataout <= rxsr;
                    sddo       <= SPI_IDLE_MOSI;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end else begin
                    txsr   <= {txsr[5:0], 1'b1};
                    sddo   <= txsr[6];
                    bitcnt <= bitcnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: scoreboard bench for the SD SPI master (loopback and slave-pattern MISO).
module tb_sd_spi_master;

    typedef struct {
        logic [7:0] data;
        int         len;
    } exp_t;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       sd_start;
    logic [7:0] sd_datain;
    logic       speed;
    logic [7:0] sd_dataout;
    logic       busy, done, sdclk, sddo, sddi;

    logic       loop_en, slave_load, abort, mosi_ones;
    logic [7:0] slave_pat, slave_sr;
    int         exp_h;
    exp_t       exp_q[$];

    int         checks = 0;
    int         errors = 0;

    logic       prev_busy, prev_sdclk, prev_sddo, prev_done;
    int         run, busy_run, done_cnt;
    logic [7:0] last_out;
    exp_t       e;

    sd_spi_master dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .sd_start   (sd_start),
        .sd_datain  (sd_datain),
        .speed      (speed),
        .sd_dataout (sd_dataout),
        .busy       (busy),
        .done       (done),
        .sdclk      (sdclk),
        .sddo       (sddo),
        .sddi       (sddi)
    );

    always #5 fclk = ~fclk;

    // slave shifts its next MISO bit out just after each falling SCK edge
    always @(negedge sdclk or posedge slave_load) begin
        if (slave_load)
            slave_sr <= slave_pat;
        else
            slave_sr <= {slave_sr[6:0], 1'b1};
    end

    assign sddi = loop_en ? sddo : slave_sr[7];

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge fclk) begin
        if (!rst_n) begin
            last_out   = 8'hFF;
            busy_run   = 0;
            run        = 0;
            prev_busy  = 1'b0;
            prev_sdclk = 1'b0;
            prev_sddo  = 1'b1;
            prev_done  = 1'b0;
        end else begin
            if (busy && !abort)
                chk("dataout_hold", int'(sd_dataout), int'(last_out));
            if (busy && mosi_ones)
                chk("mosi_high", int'(sddo), 1);
            if (prev_sdclk && sdclk)
                chk("mosi_stable_sck_high", int'(sddo), int'(prev_sddo));
            if (!abort) begin
                if (busy && prev_busy && sdclk == prev_sdclk)
                    run++;
                else begin
                    if (prev_busy)
                        chk("sck_phase_len", run, exp_h);
                    run = busy ? 1 : 0;
                end
            end
            if (done) begin
                chk("done_width", int'(prev_done), 0);
                chk("sb_has_entry", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rx_byte", int'(sd_dataout), int'(e.data));
                    chk("busy_len", busy_run, e.len);
                end
                chk("done_busy_low", int'(busy), 0);
                chk("done_sddo_idle", int'(sddo), 1);
                chk("done_sdclk_low", int'(sdclk), 0);
                last_out = sd_dataout;
                done_cnt++;
            end
            busy_run   = busy ? busy_run + 1 : 0;
            prev_busy  = busy;
            prev_sdclk = sdclk;
            prev_sddo  = sddo;
            prev_done  = done;
        end
    end

    task automatic start_pulse(input logic [7:0] d, input logic spd);
        sd_datain = d;
        speed     = spd;
        sd_start  = 1'b1;
        @(negedge fclk);
        sd_start  = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input int len);
        exp_t x;
        x.data = d;
        x.len  = len;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            @(negedge fclk);
            n++;
        end
        chk("done_within_budget", int'(n < lim), 1);
    endtask

    task automatic run_xfer(input logic [7:0] d, input logic [7:0] rx, input logic spd);
        int n;
        @(negedge fclk);
        exp_h = spd ? 1 : 64;
        push_exp(rx, 16 * exp_h);
        start_pulse(d, spd);
        wait_done(16 * exp_h + 8, n);
    endtask

    task automatic load_slave(input logic [7:0] p);
        slave_pat  = p;
        slave_load = 1'b1;
        #1 slave_load = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        sd_start   = 1'b0;
        sd_datain  = 8'hFF;
        speed      = 1'b1;
        loop_en    = 1'b1;
        slave_load = 1'b0;
        slave_pat  = 8'hFF;
        abort      = 1'b0;
        mosi_ones  = 1'b0;
        exp_h      = 1;
        done_cnt   = 0;
        load_slave(8'hFF);
        repeat (3) @(negedge fclk);
        rst_n = 1'b1;
        @(negedge fclk);
        chk("rst_sdclk", int'(sdclk), 0);
        chk("rst_sddo", int'(sddo), 1);
        chk("rst_dataout", int'(sd_dataout), 8'hFF);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        run_xfer(8'hA5, 8'hA5, 1'b1);
        @(negedge fclk);
        chk("idle_sddo_after_a5", int'(sddo), 1);

        // abort a slow transfer part-way through a HIGH phase
        abort = 1'b1;
        exp_h = 64;
        start_pulse(8'h5A, 1'b0);
        n = 0;
        while (!sdclk && n < 200) begin
            @(negedge fclk);
            n++;
        end
        chk("reached_high_phase", int'(sdclk), 1);
        repeat (10) @(negedge fclk);
        rst_n = 1'b0;
        #1;
        chk("abort_sdclk", int'(sdclk), 0);
        chk("abort_sddo", int'(sddo), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dataout", int'(sd_dataout), 8'hFF);
        chk("abort_done", int'(done), 0);
        repeat (2) @(negedge fclk);
        rst_n = 1'b1;
        @(negedge fclk);
        abort = 1'b0;
        run_xfer(8'hC3, 8'hC3, 1'b1);

        loop_en = 1'b0;
        load_slave(8'h3C);
        mosi_ones = 1'b1;
        run_xfer(8'hFF, 8'h3C, 1'b0);
        mosi_ones = 1'b0;

        // a second request mid-transfer, with a different byte and rate, must vanish
        loop_en = 1'b1;
        @(negedge fclk);
        exp_h = 1;
        push_exp(8'hFF, 16);
        start_pulse(8'hFF, 1'b1);
        repeat (3) @(negedge fclk);
        start_pulse(8'h00, 1'b0);
        wait_done(40, n);

        @(negedge fclk);
        exp_h = 1;
        push_exp(8'h12, 16);
        start_pulse(8'h12, 1'b1);
        wait_done(40, n);
        push_exp(8'h34, 16);
        start_pulse(8'h34, 1'b1);
        wait_done(40, n);
        chk("b2b_start_to_done", n, 16);

        loop_en = 1'b0;
        load_slave(8'h81);
        run_xfer(8'h00, 8'h81, 1'b1);

        repeat (4) @(negedge fclk);
        chk("done_count", done_cnt, 7);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
